// File: rtl/clint_axil_bridge.sv
// AXI4-Lite slave to BRAM-port bridge for the CLINT control window.
// One transaction in flight; reads and writes alternate priority on ties.
module clint_axil_bridge #(
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [63:0]           s_wdata,
  input  logic [7:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [63:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  output logic [7:0]            bram_we,
  output logic [63:0]           bram_wrdata,
  input  logic [63:0]           bram_rddata
);

  // Handshake rule: a channel transfers in a cycle where both valid and ready
  // are high at the rising edge; readys here depend combinationally on valids.

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ISSUE = 3'd1,
    WR_RESP  = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4,
    RD_RESP  = 3'd5
  } state_t;

  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

  state_t                  state_q, state_d;
  logic                    rd_prio_q, rd_prio_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [63:0]             wrdata_q, wrdata_d;
  logic [7:0]              we_q, we_d;
  logic [63:0]             rdata_q, rdata_d;
  logic [1:0]              lat_cnt_q, lat_cnt_d;

  logic idle_ok;
  logic wr_req;
  logic rd_grant;
  logic wr_grant;
  logic unused_addr_bits;

  // Readys are gated by rst so they read 0 while reset is held.
  assign idle_ok  = (state_q == IDLE) && !rst;
  assign wr_req   = s_awvalid && s_wvalid;
  assign rd_grant = idle_ok && s_arvalid && (!wr_req || rd_prio_q);
  assign wr_grant = idle_ok && wr_req && (!s_arvalid || !rd_prio_q);

  assign unused_addr_bits = ^{s_awaddr[2:0], s_araddr[2:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_prio_q <= 1'b1;
      addr_q    <= '0;
      wrdata_q  <= '0;
      we_q      <= '0;
      rdata_q   <= '0;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_prio_q <= rd_prio_d;
      addr_q    <= addr_d;
      wrdata_q  <= wrdata_d;
      we_q      <= we_d;
      rdata_q   <= rdata_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_prio_d = rd_prio_q;
    addr_d    = addr_q;
    wrdata_d  = wrdata_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    lat_cnt_d = lat_cnt_q;
    case (state_q)
      IDLE: begin
        // The granted side yields the next tie to the other side.
        if (rd_grant) begin
          state_d   = RD_ISSUE;
          addr_d    = {s_araddr[ADDR_WIDTH-1:3], 3'b000};
          rd_prio_d = 1'b0;
        end else if (wr_grant) begin
          state_d   = WR_ISSUE;
          addr_d    = {s_awaddr[ADDR_WIDTH-1:3], 3'b000};
          wrdata_d  = s_wdata;
          we_d      = s_wstrb;
          rd_prio_d = 1'b1;
        end
      end
      WR_ISSUE: state_d = WR_RESP;
      WR_RESP:  if (s_bready) state_d = IDLE;
      RD_ISSUE: begin
        state_d   = RD_WAIT;
        lat_cnt_d = '0;
      end
      RD_WAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          rdata_d = bram_rddata;
          state_d = RD_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end
      RD_RESP:  if (s_rready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign s_awready   = wr_grant;
  assign s_wready    = wr_grant;
  assign s_arready   = rd_grant;
  assign s_bvalid    = (state_q == WR_RESP);
  assign s_rvalid    = (state_q == RD_RESP);
  assign s_bresp     = 2'b00;
  assign s_rresp     = 2'b00;
  assign s_rdata     = rdata_q;
  assign bram_en     = (state_q == WR_ISSUE) || (state_q == RD_ISSUE);
  assign bram_we     = (state_q == WR_ISSUE) ? we_q : 8'h00;
  assign bram_addr   = addr_q;
  assign bram_wrdata = wrdata_q;

endmodule

// File: tb/tb_clint_axil_bridge.sv
// Directed bench for clint_axil_bridge: vector table of single transactions
// plus hand-written arbitration, backpressure, reset and latency sequences.
module tb_clint_axil_bridge;

  localparam int AW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, rst2;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic          s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [63:0]   s_wdata, bram_rddata;
  logic [7:0]    s_wstrb;

  logic          s_awready, s_wready, s_bvalid, s_arready, s_rvalid, bram_en;
  logic [1:0]    s_bresp, s_rresp;
  logic [63:0]   s_rdata, bram_wrdata;
  logic [AW-1:0] bram_addr;
  logic [7:0]    bram_we;

  logic          s_awready2, s_wready2, s_bvalid2, s_arready2, s_rvalid2, bram_en2;
  logic [1:0]    s_bresp2, s_rresp2;
  logic [63:0]   s_rdata2, bram_wrdata2;
  logic [AW-1:0] bram_addr2;
  logic [7:0]    bram_we2;

  clint_axil_bridge #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
    .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata)
  );

  clint_axil_bridge #(.ADDR_WIDTH(AW), .READ_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst2),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready2),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready2),
    .s_bresp(s_bresp2), .s_bvalid(s_bvalid2), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready2),
    .s_rdata(s_rdata2), .s_rresp(s_rresp2), .s_rvalid(s_rvalid2), .s_rready(s_rready),
    .bram_addr(bram_addr2), .bram_en(bram_en2), .bram_we(bram_we2),
    .bram_wrdata(bram_wrdata2), .bram_rddata(bram_rddata)
  );

  typedef struct {
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [63:0]   wdata;
    logic [7:0]    wstrb;
    logic [63:0]   rd;
    logic [AW-1:0] exp_addr;
    logic [7:0]    exp_we;
    logic [63:0]   exp_rdata;
  } vec_t;

  vec_t vecs[6];
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic do_write(input vec_t v, input string tag);
    step();
    s_awaddr = v.addr; s_wdata = v.wdata; s_wstrb = v.wstrb;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
    settle();
    chk({tag, " awready"}, 64'(s_awready), 64'd1);
    chk({tag, " wready"}, 64'(s_wready), 64'd1);
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_awaddr = '0; s_wdata = '0; s_wstrb = '0;
    settle();
    chk({tag, " en"}, 64'(bram_en), 64'd1);
    chk({tag, " we"}, 64'(bram_we), 64'(v.exp_we));
    chk({tag, " addr"}, 64'(bram_addr), 64'(v.exp_addr));
    chk({tag, " wrdata"}, bram_wrdata, v.wdata);
    chk({tag, " bvalid early"}, 64'(s_bvalid), 64'd0);
    step(); settle();
    chk({tag, " en off"}, 64'(bram_en), 64'd0);
    chk({tag, " we off"}, 64'(bram_we), 64'd0);
    chk({tag, " bvalid"}, 64'(s_bvalid), 64'd1);
    chk({tag, " bresp"}, 64'(s_bresp), 64'd0);
    chk({tag, " wrdata held"}, bram_wrdata, v.wdata);
    step(); settle();
    chk({tag, " bvalid done"}, 64'(s_bvalid), 64'd0);
  endtask

  task automatic do_read(input vec_t v, input string tag);
    step();
    s_araddr = v.addr; s_arvalid = 1'b1; s_rready = 1'b1;
    bram_rddata = 64'hBAD0_BAD0_BAD0_BAD0;
    settle();
    chk({tag, " arready"}, 64'(s_arready), 64'd1);
    step();
    s_arvalid = 1'b0; s_araddr = '0;
    settle();
    chk({tag, " en"}, 64'(bram_en), 64'd1);
    chk({tag, " we"}, 64'(bram_we), 64'd0);
    chk({tag, " addr"}, 64'(bram_addr), 64'(v.exp_addr));
    step();
    bram_rddata = v.rd;
    settle();
    chk({tag, " en off"}, 64'(bram_en), 64'd0);
    chk({tag, " rvalid early"}, 64'(s_rvalid), 64'd0);
    step();
    bram_rddata = ~v.rd;
    settle();
    chk({tag, " rvalid"}, 64'(s_rvalid), 64'd1);
    chk({tag, " rdata"}, s_rdata, v.exp_rdata);
    chk({tag, " rresp"}, 64'(s_rresp), 64'd0);
    step(); settle();
    chk({tag, " rvalid done"}, 64'(s_rvalid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t wv;
    int n;
    logic [63:0] held;

    vecs[0] = '{1'b1, 16'h4000, 64'h0000_0000_DEAD_BEEF, 8'h0F, 64'h0,
                16'h4000, 8'h0F, 64'h0};
    vecs[1] = '{1'b0, 16'hBFFD, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF,
                16'hBFF8, 8'h00, 64'h0123_4567_89AB_CDEF};
    vecs[2] = '{1'b1, 16'h0007, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'h0,
                16'h0000, 8'h00, 64'h0};
    vecs[3] = '{1'b1, 16'hFFFF, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 64'h0,
                16'hFFF8, 8'hFF, 64'h0};
    vecs[4] = '{1'b0, 16'h0000, 64'h0, 8'h00, 64'hFEDC_BA98_7654_3210,
                16'h0000, 8'h00, 64'hFEDC_BA98_7654_3210};
    vecs[5] = '{1'b0, 16'h7FFF, 64'h0, 8'h00, 64'h5555_AAAA_5555_AAAA,
                16'h7FF8, 8'h00, 64'h5555_AAAA_5555_AAAA};

    rst = 1'b1; rst2 = 1'b1;
    s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0; bram_rddata = '0;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    s_bready = 1'b0; s_rready = 1'b0;
    repeat (2) @(posedge clk);
    #4;
    chk("reset awready", 64'(s_awready), 64'd0);
    chk("reset wready", 64'(s_wready), 64'd0);
    chk("reset arready", 64'(s_arready), 64'd0);
    chk("reset bvalid", 64'(s_bvalid), 64'd0);
    chk("reset rvalid", 64'(s_rvalid), 64'd0);
    chk("reset rdata", s_rdata, 64'd0);
    chk("reset bresp", 64'(s_bresp), 64'd0);
    chk("reset rresp", 64'(s_rresp), 64'd0);
    chk("reset bram_en", 64'(bram_en), 64'd0);
    chk("reset bram_we", 64'(bram_we), 64'd0);
    chk("reset bram_addr", 64'(bram_addr), 64'd0);
    chk("reset bram_wrdata", bram_wrdata, 64'd0);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    step();
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i], $sformatf("vec%0d wr", i));
      else               do_read(vecs[i], $sformatf("vec%0d rd", i));
    end

    // All three request channels held valid from reset.
    step(); rst = 1'b1; step(); rst = 1'b0;
    s_awaddr = 16'h0100; s_wdata = 64'h1; s_wstrb = 8'hFF; s_araddr = 16'h0200;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    s_bready = 1'b1; s_rready = 1'b1;
    exp_q = '{8'h52, 8'h57, 8'h52, 8'h57};
    got_q = {};
    n = 0;
    for (int cyc = 0; cyc < 60 && got_q.size() < 4; cyc++) begin
      settle();
      if (s_arready && s_awready) got_q.push_back(8'h58);
      else if (s_arready) got_q.push_back(8'h52);
      else if (s_awready) got_q.push_back(s_wready ? 8'h57 : 8'h3F);
      step();
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    chk("arb grant count", 64'(got_q.size()), 64'd4);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      n++;
      chk($sformatf("arb grant %0d", n), 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    end
    repeat (6) step();

    // Lone AW must wait for W.
    s_awaddr = 16'h123D; s_wdata = 64'h1111_2222_3333_4444; s_wstrb = 8'hF0;
    s_awvalid = 1'b1; s_wvalid = 1'b0; s_bready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk($sformatf("lone aw awready c%0d", k), 64'(s_awready), 64'd0);
      chk($sformatf("lone aw wready c%0d", k), 64'(s_wready), 64'd0);
      step();
    end
    s_wvalid = 1'b1;
    settle();
    chk("aw+w awready", 64'(s_awready), 64'd1);
    chk("aw+w wready", 64'(s_wready), 64'd1);
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    settle();
    chk("aw+w en", 64'(bram_en), 64'd1);
    chk("aw+w addr", 64'(bram_addr), 64'h1238);
    chk("aw+w we", 64'(bram_we), 64'hF0);
    step(); step(); settle();
    chk("aw+w bvalid done", 64'(s_bvalid), 64'd0);

    // Read response stalled by rready while BRAM data keeps changing.
    step();
    held = 64'hCAFE_F00D_1234_5678;
    s_araddr = 16'h2222; s_arvalid = 1'b1; s_rready = 1'b0;
    settle();
    chk("bp arready", 64'(s_arready), 64'd1);
    step(); settle();
    chk("bp arready busy", 64'(s_arready), 64'd0);
    step();
    bram_rddata = held;
    for (int k = 0; k < 4; k++) begin
      step();
      bram_rddata = {$urandom(), $urandom()};
      settle();
      chk($sformatf("bp rvalid c%0d", k), 64'(s_rvalid), 64'd1);
      chk($sformatf("bp rdata c%0d", k), s_rdata, held);
      chk($sformatf("bp arready c%0d", k), 64'(s_arready), 64'd0);
    end
    step();
    s_rready = 1'b1;
    settle();
    chk("bp rvalid at hs", 64'(s_rvalid), 64'd1);
    chk("bp arready at hs", 64'(s_arready), 64'd0);
    step(); settle();
    chk("bp rvalid after hs", 64'(s_rvalid), 64'd0);
    chk("bp new arready", 64'(s_arready), 64'd1);
    step();
    s_arvalid = 1'b0;
    repeat (5) step();

    // Reset while waiting on BRAM read data.
    s_araddr = 16'h3000; s_arvalid = 1'b1; s_rready = 1'b1;
    settle();
    chk("rst arready", 64'(s_arready), 64'd1);
    step(); step(); settle();
    rst = 1'b1;
    #1;
    chk("rst now rvalid", 64'(s_rvalid), 64'd0);
    chk("rst now bram_en", 64'(bram_en), 64'd0);
    chk("rst now arready", 64'(s_arready), 64'd0);
    step(); settle();
    chk("rst held rvalid", 64'(s_rvalid), 64'd0);
    chk("rst held arready", 64'(s_arready), 64'd0);
    chk("rst held bram_en", 64'(bram_en), 64'd0);
    s_arvalid = 1'b0;
    step();
    rst = 1'b0;
    wv = '{1'b1, 16'h0A0C, 64'h0BAD_C0DE_0000_0001, 8'h3C, 64'h0,
           16'h0A08, 8'h3C, 64'h0};
    do_write(wv, "post-rst wr");

    // Latency 1 and latency 2 instances side by side on one read.
    step(); rst = 1'b1; rst2 = 1'b1; step(); rst = 1'b0; rst2 = 1'b0;
    step();
    s_araddr = 16'h080B; s_arvalid = 1'b1; s_rready = 1'b0;
    settle();
    chk("lat2 arready", 64'(s_arready2), 64'd1);
    step();
    s_arvalid = 1'b0;
    settle();
    chk("lat2 en", 64'(bram_en2), 64'd1);
    chk("lat2 addr", 64'(bram_addr2), 64'h0808);
    step();
    bram_rddata = 64'h1111_1111_1111_1111;
    settle();
    chk("lat2 rvalid t2", 64'(s_rvalid2), 64'd0);
    chk("lat2 en off", 64'(bram_en2), 64'd0);
    step();
    bram_rddata = 64'h2222_2222_2222_2222;
    settle();
    chk("lat1 rvalid t3", 64'(s_rvalid), 64'd1);
    chk("lat1 rdata t3", s_rdata, 64'h1111_1111_1111_1111);
    chk("lat2 rvalid t3", 64'(s_rvalid2), 64'd0);
    step();
    bram_rddata = 64'h3333_3333_3333_3333;
    settle();
    chk("lat2 rvalid t4", 64'(s_rvalid2), 64'd1);
    chk("lat2 rdata t4", s_rdata2, 64'h2222_2222_2222_2222);
    chk("lat2 rresp", 64'(s_rresp2), 64'd0);
    s_rready = 1'b1;
    step(); settle();
    chk("lat2 rvalid done", 64'(s_rvalid2), 64'd0);
    chk("lat1 rvalid done", 64'(s_rvalid), 64'd0);
    rst2 = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clint_axil_bridge.md
Name: clint_axil_bridge

Overview:
AXI4-Lite slave to BRAM-port bridge that sits directly upstream of the CLINT and drives its 64 KiB, 64-bit, read-latency-1 BRAM control port. Converts single-beat AXI4-Lite reads and writes from the system interconnect into BRAM enable/write-strobe cycles and returns OKAY responses. One transaction is in flight at a time. Read/write arbitration is fair.

Parameters:
ADDR_WIDTH, 16, byte-address width of both the AXI and BRAM sides; 16 covers the 64 KiB window.
READ_LATENCY, 1, BRAM read latency in cycles; legal values are 1 or 2.

Ports:
clk  input  1  sole clock; the AXI and BRAM sides are both synchronous to it.
rst  input  1  asynchronous, active-high reset.
s_awaddr  input  ADDR_WIDTH  write address (byte).
s_awvalid  input  1  write address valid.
s_awready  output  1  write address ready.
s_wdata  input  64  write data.
s_wstrb  input  8  write byte strobes.
s_wvalid  input  1  write data valid.
s_wready  output  1  write data ready.
s_bresp  output  2  write response; always 2'b00.
s_bvalid  output  1  write response valid.
s_bready  input  1  write response ready.
s_araddr  input  ADDR_WIDTH  read address (byte).
s_arvalid  input  1  read address valid.
s_arready  output  1  read address ready.
s_rdata  output  64  read data.
s_rresp  output  2  read response; always 2'b00.
s_rvalid  output  1  read data valid.
s_rready  input  1  read data ready.
bram_addr  output  ADDR_WIDTH  BRAM byte address; bits [2:0] are always 0.
bram_en  output  1  BRAM enable.
bram_we  output  8  BRAM byte write enables.
bram_wrdata  output  64  BRAM write data.
bram_rddata  input  64  BRAM read data, valid READ_LATENCY cycles after bram_en with bram_we==0.

Behaviour:
- Reset values: all outputs 0. These are s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_rdata, s_bresp, s_rresp, bram_en, bram_we, bram_addr and bram_wrdata. FSM resets to IDLE, and the priority flag resets to "read first".
- FSM states: IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP.
- Ready signals:
  - s_awready, s_wready and s_arready are combinational.
  - They can only be high in IDLE.
  - AW and W are accepted together only. s_awready = s_wready = IDLE & s_awvalid & s_wvalid & write_granted.
  - A lone AW or a lone W is never accepted.
  - s_arready = IDLE & s_arvalid & read_granted.
- Arbitration in IDLE:
  - If only one request type is valid, it is granted.
  - If both are valid, the priority flag decides.
  - The flag flips after each granted transaction, so the loser of a tie always wins the next one.
- Write sequence (handshake in cycle T):
  - Cycle T+1 is WR_ISSUE: bram_en=1, bram_we=s_wstrb (registered), bram_addr={awaddr[ADDR_WIDTH-1:3],3'b0}, bram_wrdata=s_wdata.
  - Cycle T+2 is WR_RESP with s_bvalid=1, held until s_bready; then return to IDLE.
  - Earliest new handshake is 1 cycle after the bvalid&bready cycle.
- A write with wstrb=0 still performs the BRAM cycle (bram_en=1, bram_we=0) and is responded to normally.
- Read sequence (handshake in cycle T):
  - Cycle T+1 is RD_ISSUE: bram_en=1, bram_we=0, bram_addr aligned as for writes.
  - Then RD_WAIT for READ_LATENCY cycles, with bram_en=0 and a latency counter running.
  - s_rdata is captured from bram_rddata at the end of the last RD_WAIT cycle.
  - From cycle T+2+READ_LATENCY the FSM is in RD_RESP with s_rvalid=1. This is T+3 for latency 1.
  - s_rdata is held stable while s_rvalid & !s_rready; return to IDLE on the handshake.
- bram_en is high for exactly one cycle per transaction. bram_we is 0 outside WR_ISSUE. bram_addr and bram_wrdata hold their last value otherwise.
- Address bits [2:0] are ignored on both channels; unaligned addresses access the containing 8-byte word.
- Responses are never SLVERR or DECERR.
- Backpressure:
  - A stalled bready or rready blocks all further acceptance. There is no buffering beyond one transaction.
  - Valid signals from the master may drop before the handshake; nothing is latched unless ready was high.
- Reset mid-operation: asserting rst in any state forces IDLE and clears all valids and bram_en immediately (asynchronously). The in-flight transaction is dropped with no response.

Test Plan:
- Write awaddr=0x4000, wdata=0x0000_0000_DEAD_BEEF, wstrb=0x0F, bready=1 -> one bram_en pulse with bram_addr=0x4000, bram_we=0x0F, bram_wrdata=0x0000_0000_DEAD_BEEF; bvalid 2 cycles after the handshake; bresp=00.
- Read araddr=0xBFFD with bram_rddata=0x0123_4567_89AB_CDEF on the cycle after en -> bram_addr=0xBFF8; rvalid at T+3 with rdata=0x0123_4567_89AB_CDEF and rresp=00. With READ_LATENCY=2, rvalid appears at T+4.
- AW, W and AR all valid together from reset, held continuously -> read is granted first, then the write, then reads and writes alternate.
- AW valid with W low for 5 cycles, then W raised -> awready stays 0 until W rises; the handshake happens in the same cycle on both channels.
- Read completes with rready held low for 4 cycles while bram_rddata changes -> rdata stays stable; no new AR is accepted until the rready handshake.
- Assert rst during RD_WAIT -> rvalid, bram_en and the ready signals go to 0 immediately; after release, a new write completes normally.
